// File: rtl/iot_frame_sched_if.sv
// Bundles the configuration, requester, engine and result signals of the
// IoT frame scheduler. The scheduler uses the slave modport; whoever drives
// requests and models the engine uses the master modport.
interface iot_frame_sched_if #(
  parameter int NUM_SRC = 4
);
  logic                     cfg_start;
  logic                     cfg_stop;
  logic [2:0]               cfg_fn_sel;
  logic [NUM_SRC-1:0]       src_req;
  logic [NUM_SRC*128-1:0]   src_data;
  logic [NUM_SRC-1:0]       src_ack;
  logic                     df_busy;
  logic                     df_valid;
  logic [127:0]             df_out;
  logic                     in_en;
  logic [7:0]               iot_in;
  logic [2:0]               fn_sel;
  logic                     res_valid;
  logic [127:0]             res_data;
  logic [7:0]               res_round;
  logic                     sched_busy;

  modport master (
    output cfg_start, cfg_stop, cfg_fn_sel, src_req, src_data, df_busy, df_valid, df_out,
    input  src_ack, in_en, iot_in, fn_sel, res_valid, res_data, res_round, sched_busy
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_fn_sel, src_req, src_data, df_busy, df_valid, df_out,
    output src_ack, in_en, iot_in, fn_sel, res_valid, res_data, res_round, sched_busy
  );
endinterface

// File: rtl/iot_frame_sched.sv
// Front-end scheduler for the IoT data-filter engine: round-robin grant of
// 128-bit frames, MSB-byte-first serialisation against engine busy, frame and
// round bookkeeping, and round-tagged capture of engine results.
module iot_frame_sched #(
  parameter int NUM_SRC   = 4,
  parameter int ROUND_LEN = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  iot_frame_sched_if.slave  bus
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int FW = $clog2(ROUND_LEN + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [7:0]           round_q, round_d;
  logic [3:0]           k_q, k_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic                 stop_q, stop_d;
  logic [127:0]         frame_q, frame_d;
  logic [2:0]           fn_sel_q, fn_sel_d;
  logic                 in_en_q, in_en_d;
  logic [7:0]           iot_in_q, iot_in_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 res_valid_q, res_valid_d;
  logic [127:0]         res_data_q, res_data_d;
  logic [7:0]           res_round_q, res_round_d;

  logic [127:0]         src_arr [NUM_SRC];
  logic                 found;
  logic [PW-1:0]        win;
  logic [PW-1:0]        idx;
  logic                 boundary;

  // Unpack the flat source bus into one frame per requester.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_arr[i] = bus.src_data[i*128 +: 128];
  end

  // Round-robin search: first asserted request at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = PW'((int'(rr_q) + i) % NUM_SRC);
      if (!found && bus.src_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and next-output computation for the whole scheduler.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    fcnt_d    = fcnt_q;
    round_d   = round_q;
    k_d       = k_q;
    dcnt_d    = dcnt_q;
    stop_d    = stop_q;
    frame_d   = frame_q;
    fn_sel_d  = fn_sel_q;
    in_en_d   = in_en_q;
    iot_in_d  = iot_in_q;
    ack_d     = '0;
    boundary  = 1'b0;

    // Result capture runs regardless of state; the tag is the pre-increment round.
    res_valid_d = bus.df_valid;
    res_data_d  = bus.df_valid ? bus.df_out : res_data_q;
    res_round_d = bus.df_valid ? round_q    : res_round_q;

    if (state_q != IDLE && bus.cfg_stop) stop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          fn_sel_d = bus.cfg_fn_sel;
          round_d  = '0;
          fcnt_d   = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (found) begin
          frame_d    = src_arr[win];
          ack_d[win] = 1'b1;
          rr_d       = (int'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;
          k_d        = '0;
          in_en_d    = 1'b1;
          iot_in_d   = src_arr[win][127:120];
          state_d    = SEND;
        end
      end
      SEND: begin
        // The byte on the bus is consumed only on an edge where the engine is free.
        if (!bus.df_busy) begin
          if (k_q == 4'd15) begin
            in_en_d = 1'b0;
            state_d = WAIT;
          end else begin
            k_d      = k_q + 4'd1;
            iot_in_d = frame_q[{4'd14 - k_q, 3'b000} +: 8];
          end
        end
      end
      WAIT: begin
        // Engine dropping busy marks the end of processing for this frame.
        if (!bus.df_busy) begin
          if (fcnt_q == FW'(ROUND_LEN - 1)) begin
            fcnt_d   = '0;
            round_d  = round_q + 8'd1;
            boundary = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
          dcnt_d  = '0;
          state_d = (stop_d && boundary) ? DRAIN : GRANT;
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(DRAIN_CYC - 1)) begin
          stop_d  = 1'b0;
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      fcnt_q      <= '0;
      round_q     <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      stop_q      <= 1'b0;
      frame_q     <= '0;
      fn_sel_q    <= '0;
      in_en_q     <= 1'b0;
      iot_in_q    <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_round_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      fcnt_q      <= fcnt_d;
      round_q     <= round_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      stop_q      <= stop_d;
      frame_q     <= frame_d;
      fn_sel_q    <= fn_sel_d;
      in_en_q     <= in_en_d;
      iot_in_q    <= iot_in_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_round_q <= res_round_d;
    end
  end

  assign bus.src_ack    = ack_q;
  assign bus.in_en      = in_en_q;
  assign bus.iot_in     = iot_in_q;
  assign bus.fn_sel     = fn_sel_q;
  assign bus.sched_busy = busy_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_round  = res_round_q;
endmodule
